led_event_flasher: RTL and testbench
====================================

# led_event_flasher

Output-side counterpart of the button input chain: converts single-cycle internal event pulses into human-visible LED flashes. Each event on a channel produces one fixed-length on-period followed by a guaranteed off-gap, so back-to-back events remain distinguishable by eye. It sits between edge-detected or internal event sources and the board LED pins, one independent channel per bit.

## Interface

- `width`, 1: number of independent channels.
- `on_count_max`, 2500000: LED on-time per flash, in `clk` cycles (≥1).
- `off_count_max`, 1250000: minimum LED off-gap after each flash, in `clk` cycles (≥1).
- `queue_max`, 7: saturation value of the per-channel pending-event counter (≥1). Used only with `LED_FLASH_QUEUE_EN`.

Ports:

- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in` input, `width` bits: event pulses, synchronous to `clk`. Every cycle a bit is high counts as one event.
- `out` output, `width` bits: LED drive, registered.
- `busy` output, `width` bits: registered; high while the channel is not IDLE.

## Operation

- Each channel has a 3-state FSM: IDLE, ON, GAP. It also has a down-counter wide enough for `max(on_count_max, off_count_max)-1`. With the macro, it also has a pending counter of `$clog2(queue_max+1)` bits.
- `out[i]` is high exactly when the state is ON. `busy[i]` is high when the state is ON or GAP. Both are registered alongside the state.
- IDLE: an event moves the channel to ON and loads the counter with `on_count_max-1`.
- ON: the counter decrements each cycle. At 0 the channel moves to GAP and loads `off_count_max-1`.
- GAP: the counter decrements each cycle. At 0:
  - If an event is present that cycle, or pending > 0, the channel moves to ON and loads `on_count_max-1`. Pending decrements only when it was used, i.e. no event is present that cycle.
  - Otherwise the channel moves to IDLE.
- Events during ON, or during GAP other than the expiry cycle:
  - With the macro, pending increments, saturating at `queue_max`. Further events are dropped.
  - Without the macro, these events are dropped.
- An event and a pending decrement in the same cycle leave pending unchanged.
- Channels are fully independent. There is no cross-channel arbitration.

## Timing

- Reset: a cycle with `rst` high sets every channel to IDLE, counter 0, pending 0. `out` and `busy` are 0 from the next cycle.
- Reset mid-flash or mid-gap aborts immediately. Queued events are discarded.
- `rst` takes priority over a coincident `in` pulse.
- Latency: an event sampled at edge t gives `out` high during cycles t+1 … t+`on_count_max`.
- After the on-time, `out` is low for at least `off_count_max` cycles.
- `busy` stays high through the gap and falls `on_count_max`+`off_count_max` cycles after the flash started, unless a new flash follows.
- Back-to-back queued flashes therefore start every `on_count_max`+`off_count_max` cycles.
- An event on the GAP expiry cycle chains directly into ON, with no IDLE cycle.
- Counters never wrap: all loads are `max-1` and transitions fire at 0.

## Configuration

- `LED_FLASH_QUEUE_EN` defined: the pending counter is present. Events arriving while busy are each replayed as a separate flash, up to `queue_max` outstanding.
- `LED_FLASH_QUEUE_EN` undefined: no pending counter. Events during ON, or during GAP before the expiry cycle, are ignored. An event on the GAP expiry cycle still starts a flash.

## Test plan

All scenarios use `on_count_max`=4, `off_count_max`=3, `queue_max`=2.

1. Reset: `rst` high cycles 0–2 with `in`=1 → `out`=0 and `busy`=0 through cycle 3; no flash afterwards.
2. Single pulse at cycle 10 → `out` high cycles 11–14, low from 15; `busy` high 11–17, low at 18.
3. With the macro, pulses at cycles 10, 11, 12 → `out` high 11–14, 18–21, 25–28; `busy` falls at 32.
4. Saturation: pulses at cycles 10–13.
   - With the macro: exactly three flashes (11–14, 18–21, 25–28).
   - Without the macro: a single flash 11–14.
5. Chain: pulse at cycle 10, second pulse at cycle 17 (GAP expiry), no queue → `out` high 11–14 and 18–21; `busy` continuously high 11–24.
6. `width`=2: pulse on ch0 at cycle 10, ch1 at cycle 12, `rst` at cycle 13 → both `out` low at 14 and `busy` 0; pulse on ch1 at cycle 20 → `out[1]` high 21–24 and `out[0]` stays 0.

Source files
------------

// File: rtl/led_event_flasher.sv
// led_event_flasher: turns single-cycle event pulses into human-visible LED
// flashes. Each event gives a fixed on-period followed by a guaranteed off-gap,
// with one fully independent channel per bit of `in`.
// Optional feature macro: LED_FLASH_QUEUE_EN adds a per-channel saturating
// pending-event counter, so events arriving while a channel is busy are
// replayed as separate flashes instead of being dropped.
module led_event_flasher #(
  parameter int width         = 1,
  parameter int on_count_max  = 2500000,
  parameter int off_count_max = 1250000,
  parameter int queue_max     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic [width-1:0] busy
);

  // The counter only ever holds max-1, so $clog2(max) bits suffice (min 1).
  localparam int CNT_MAX = (on_count_max > off_count_max) ? on_count_max : off_count_max;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] ON_LOAD  = CW'(on_count_max - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(off_count_max - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Reject zero-length timings or an empty queue at elaboration time.
  if (width < 1 || on_count_max < 1 || off_count_max < 1 || queue_max < 1) begin : g_bad_params
    $error("led_event_flasher: width, on_count_max, off_count_max and queue_max must be >= 1");
  end

  for (genvar i = 0; i < width; i++) begin : g_ch
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          out_r;
    logic          busy_r;
    logic          ev_s;
    logic          gap_expire_s;
    logic          pend_any_s;

    assign ev_s         = in[i];
    assign gap_expire_s = (state_r == ST_GAP) && (cnt_r == CNT_ZERO);

`ifdef LED_FLASH_QUEUE_EN
    localparam int PW = $clog2(queue_max + 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(queue_max);
    localparam logic [PW-1:0] PEND_ZERO = PW'(0);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    logic [PW-1:0] pend_r;
    logic [PW-1:0] pend_s;

    assign pend_any_s = (pend_r != PEND_ZERO);

    // Pending count: add busy-time events (saturating), consume one per replayed flash.
    always_comb begin
      pend_s = pend_r;
      if (gap_expire_s) begin
        // A live event on the expiry cycle starts the flash itself, so the
        // stored count is only consumed when no event is present.
        if (!ev_s && pend_any_s) begin
          pend_s = pend_r - PEND_ONE;
        end else begin
          pend_s = pend_r;
        end
      end else if ((state_r == ST_ON || state_r == ST_GAP) && ev_s && (pend_r != PEND_MAX)) begin
        pend_s = pend_r + PEND_ONE;
      end else begin
        pend_s = pend_r;
      end
    end

    // Pending register; reset discards any queued events.
    always_ff @(posedge clk) begin
      if (rst) begin
        pend_r <= PEND_ZERO;
      end else begin
        pend_r <= pend_s;
      end
    end
`else
    assign pend_any_s = 1'b0;
`endif

    // Next-state and counter logic for the IDLE -> ON -> GAP flash cycle.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
        ST_IDLE: begin
          if (ev_s) begin
            state_s = ST_ON;
            cnt_s   = ON_LOAD;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = cnt_r;
          end
        end
        ST_ON: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_GAP;
            cnt_s   = OFF_LOAD;
          end else begin
            state_s = ST_ON;
            cnt_s   = cnt_r - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (gap_expire_s) begin
            // Chain straight into the next flash without an IDLE cycle.
            if (ev_s || pend_any_s) begin
              state_s = ST_ON;
              cnt_s   = ON_LOAD;
            end else begin
              state_s = ST_IDLE;
              cnt_s   = cnt_r;
            end
          end else begin
            state_s = ST_GAP;
            cnt_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end

    // State, counter and registered LED/busy outputs derived from the next state.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= ST_IDLE;
        cnt_r   <= CNT_ZERO;
        out_r   <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        out_r   <= (state_s == ST_ON);
        busy_r  <= (state_s != ST_IDLE);
      end
    end

    assign out[i]  = out_r;
    assign busy[i] = busy_r;
  end

endmodule

// File: tb/tb_led_event_flasher.sv
// Testbench for led_event_flasher: directed test-plan scenarios followed by
// random pulses/resets, checked by a scoreboard fed from a timeline model
// (flash start cycle + pending count per channel).
module tb_led_event_flasher;

  localparam int W       = 2;
  localparam int ON      = 4;
  localparam int OFF     = 3;
  localparam int QMAX    = 2;
  localparam int PER     = ON + OFF;
  localparam int LOG_LEN = 4096;
`ifdef LED_FLASH_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic [W-1:0] busy;

  led_event_flasher #(
    .width(W), .on_count_max(ON), .off_count_max(OFF), .queue_max(QMAX)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .busy(busy)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] out;
    logic [W-1:0] busy;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           start[W];
  int           pend[W];
  logic [W-1:0] out_log[LOG_LEN];
  logic [W-1:0] busy_log[LOG_LEN];

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus and push the model's expectation for the next cycle.
  // A flash occupies cycles start..start+PER-1 and lights the LED for the first ON of them.
  task automatic drive(input logic [W-1:0] in_v, input logic rst_v);
    exp_t e;
    @(negedge clk);
    in  = in_v;
    rst = rst_v;
    for (int ch = 0; ch < W; ch++) begin
      if (rst_v) begin
        start[ch] = -1000;
        pend[ch]  = 0;
      end else if (cyc == start[ch] + PER - 1) begin
        if (in_v[ch]) begin
          start[ch] = cyc + 1;
        end else if (pend[ch] > 0) begin
          start[ch] = cyc + 1;
          pend[ch]  = pend[ch] - 1;
        end
      end else if (cyc >= start[ch] + PER) begin
        if (in_v[ch]) start[ch] = cyc + 1;
      end else if (in_v[ch] && QEN && pend[ch] < QMAX) begin
        pend[ch] = pend[ch] + 1;
      end
    end
    e.cyc = cyc + 1;
    for (int ch = 0; ch < W; ch++) begin
      e.out[ch]  = (cyc + 1 >= start[ch]) && (cyc + 1 < start[ch] + ON);
      e.busy[ch] = (cyc + 1 >= start[ch]) && (cyc + 1 < start[ch] + PER);
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle_to(input int target);
    while (cyc < target) drive('0, 1'b0);
  endtask

  // Compare one logged output bit against a constant over a window of cycles.
  task automatic check_win(input string name, input int ch, input bit use_busy,
                           input int from, input int to, input logic val);
    for (int c = from; c <= to; c++) begin
      logic a;
      a = use_busy ? busy_log[c][ch] : out_log[c][ch];
      checks++;
      if (a !== val) begin
        errors++;
        $display("FAIL %s ch%0d cycle %0d actual=%b required=%b", name, ch, c, a, val);
      end
    end
  endtask

  // Monitor: after every rising edge, pop the expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cyc < LOG_LEN) begin
          out_log[e.cyc]  = out;
          busy_log[e.cyc] = busy;
        end
        checks++;
        if (out !== e.out) begin
          errors++;
          $display("FAIL out cycle %0d actual=%b required=%b", e.cyc, out, e.out);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy cycle %0d actual=%b required=%b", e.cyc, busy, e.busy);
        end
      end
    end
  end

  // Stimulus sequence, drain, directed window checks and summary.
  initial begin
    rst = 1'b1;
    in  = '0;
    for (int ch = 0; ch < W; ch++) begin
      start[ch] = -1000;
      pend[ch]  = 0;
    end

    // Reset held with events present.
    for (int k = 0; k < 3; k++) drive(2'b11, 1'b1);
    idle_to(20);
    // Single pulse (base 20).
    idle_to(30); drive(2'b01, 1'b0); idle_to(60);
    // Three pulses (base 60).
    idle_to(70); for (int k = 0; k < 3; k++) drive(2'b01, 1'b0); idle_to(110);
    // Four pulses, saturation (base 110).
    idle_to(120); for (int k = 0; k < 4; k++) drive(2'b01, 1'b0); idle_to(160);
    // Chain on GAP expiry (base 160).
    idle_to(170); drive(2'b01, 1'b0); idle_to(177); drive(2'b01, 1'b0); idle_to(200);
    // Two channels with a mid-flash reset (base 200).
    idle_to(210); drive(2'b01, 1'b0); drive(2'b00, 1'b0); drive(2'b10, 1'b0);
    drive(2'b00, 1'b1); idle_to(220); drive(2'b10, 1'b0); idle_to(240);
    // Random pulses with occasional reset.
    for (int k = 0; k < 2000; k++) begin
      logic [W-1:0] v;
      for (int ch = 0; ch < W; ch++) v[ch] = ($urandom_range(0, 5) == 0);
      drive(v, $urandom_range(0, 99) == 0);
    end
    drive('0, 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    check_win("rst_out", 0, 1'b0, 1, 19, 1'b0);
    check_win("rst_out", 1, 1'b0, 1, 19, 1'b0);
    check_win("rst_busy", 0, 1'b1, 1, 19, 1'b0);
    check_win("rst_busy", 1, 1'b1, 1, 19, 1'b0);

    check_win("single_on", 0, 1'b0, 31, 34, 1'b1);
    check_win("single_off", 0, 1'b0, 35, 37, 1'b0);
    check_win("single_busy", 0, 1'b1, 31, 37, 1'b1);
    check_win("single_busy_fall", 0, 1'b1, 38, 38, 1'b0);

    check_win("q3_on1", 0, 1'b0, 71, 74, 1'b1);
    check_win("q3_gap1", 0, 1'b0, 75, 77, 1'b0);
    check_win("q4_on1", 0, 1'b0, 121, 124, 1'b1);
    check_win("q4_gap1", 0, 1'b0, 125, 127, 1'b0);
    if (QEN) begin
      check_win("q3_on2", 0, 1'b0, 78, 81, 1'b1);
      check_win("q3_gap2", 0, 1'b0, 82, 84, 1'b0);
      check_win("q3_on3", 0, 1'b0, 85, 88, 1'b1);
      check_win("q3_busy", 0, 1'b1, 71, 91, 1'b1);
      check_win("q3_busy_fall", 0, 1'b1, 92, 92, 1'b0);
      check_win("q4_on2", 0, 1'b0, 128, 131, 1'b1);
      check_win("q4_on3", 0, 1'b0, 135, 138, 1'b1);
      check_win("q4_no4th", 0, 1'b0, 139, 159, 1'b0);
      check_win("q4_busy_fall", 0, 1'b1, 142, 142, 1'b0);
    end else begin
      check_win("q3_drop", 0, 1'b0, 78, 91, 1'b0);
      check_win("q3_busy_fall", 0, 1'b1, 78, 78, 1'b0);
      check_win("q4_drop", 0, 1'b0, 128, 159, 1'b0);
      check_win("q4_busy_fall", 0, 1'b1, 128, 128, 1'b0);
    end

    check_win("chain_on1", 0, 1'b0, 171, 174, 1'b1);
    check_win("chain_gap", 0, 1'b0, 175, 177, 1'b0);
    check_win("chain_on2", 0, 1'b0, 178, 181, 1'b1);
    check_win("chain_busy", 0, 1'b1, 171, 184, 1'b1);
    check_win("chain_busy_fall", 0, 1'b1, 185, 185, 1'b0);

    check_win("two_ch0_on", 0, 1'b0, 211, 213, 1'b1);
    check_win("two_ch1_on", 1, 1'b0, 213, 213, 1'b1);
    check_win("two_rst_out0", 0, 1'b0, 214, 239, 1'b0);
    check_win("two_rst_out1", 1, 1'b0, 214, 220, 1'b0);
    check_win("two_rst_busy0", 0, 1'b1, 214, 239, 1'b0);
    check_win("two_rst_busy1", 1, 1'b1, 214, 220, 1'b0);
    check_win("two_ch1_flash", 1, 1'b0, 221, 224, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
